// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative Ascon permutation:
// state layout, S-box table, round constants and linear-layer rotations.
package ascon_pack;

  // Word 0 is x0; each word is 64 bits.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } perm_state_t;

  // Index is the 5-bit column {x0,x1,x2,x3,x4}; entry 31 listed first.
  localparam logic [31:0][4:0] SBOX = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };

  localparam int unsigned ROT0_A = 19;
  localparam int unsigned ROT0_B = 28;
  localparam int unsigned ROT1_A = 61;
  localparam int unsigned ROT1_B = 39;
  localparam int unsigned ROT2_A = 1;
  localparam int unsigned ROT2_B = 6;
  localparam int unsigned ROT3_A = 10;
  localparam int unsigned ROT3_B = 17;
  localparam int unsigned ROT4_A = 7;
  localparam int unsigned ROT4_B = 41;

  // High nibble counts down from F as the low nibble counts up.
  function automatic logic [7:0] round_constant(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state  after_c;
  type_state  after_s;
  logic [4:0] col;
  logic [4:0] sub;

  always_comb begin
    after_c       = state_i;
    after_c[2]    = state_i[2] ^ {56'b0, round_constant(round_i)};
    after_s       = '0;
    col           = '0;
    sub           = '0;
    for (int b = 0; b < 64; b++) begin
      col = {after_c[0][b], after_c[1][b], after_c[2][b], after_c[3][b], after_c[4][b]};
      sub = SBOX[col];
      after_s[0][b] = sub[4];
      after_s[1][b] = sub[3];
      after_s[2][b] = sub[2];
      after_s[3][b] = sub[1];
      after_s[4][b] = sub[0];
    end
  end

  always_comb begin
    state_o    = '0;
    state_o[0] = after_s[0] ^ ror64(after_s[0], ROT0_A) ^ ror64(after_s[0], ROT0_B);
    state_o[1] = after_s[1] ^ ror64(after_s[1], ROT1_A) ^ ror64(after_s[1], ROT1_B);
    state_o[2] = after_s[2] ^ ror64(after_s[2], ROT2_A) ^ ror64(after_s[2], ROT2_B);
    state_o[3] = after_s[3] ^ ror64(after_s[3], ROT3_A) ^ ror64(after_s[3], ROT3_B);
    state_o[4] = after_s[4] ^ ror64(after_s[4], ROT4_A) ^ ror64(after_s[4], ROT4_B);
  end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation, one round per clock, with the external input
// multiplexer steered by input_select (1 = fresh state, 0 = feedback).
module ascon_perm_iter
  import ascon_pack::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  nb_rounds,
  input  type_state   state_to_pc,
  output logic        input_select,
  output type_state   state_out,
  output logic        busy,
  output logic        done,
  output perm_state_t fsm_state
);

  localparam logic [3:0] MAX_R      = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

  perm_state_t state, state_n;
  logic [3:0]  count, count_n;
  logic [3:0]  eff_n;
  logic [3:0]  start_idx;
  logic [3:0]  round_idx;
  type_state   round_out;
  type_state   state_out_n;
  logic        busy_n;
  logic        done_n;

  // Out-of-range round requests fall back to the full schedule.
  always_comb begin
    eff_n = nb_rounds;
    if (nb_rounds == 4'd0 || nb_rounds > MAX_R) eff_n = MAX_R;
    start_idx = MAX_R - eff_n;
    round_idx = (state == IDLE) ? start_idx : count;
  end

  ascon_round u_round (
    .state_i (state_to_pc),
    .round_i (round_idx),
    .state_o (round_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      state_out <= state_out_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    state_out_n = state_out;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_out_n = round_out;
          count_n     = start_idx + 4'd1;
          if (eff_n > 4'd1) begin
            state_n = RUN;
            busy_n  = 1'b1;
          end else begin
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        state_out_n = round_out;
        if (count == LAST_ROUND) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          count_n = count + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign input_select = (state == IDLE);
  assign fsm_state    = state;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: bitwise reference model, expected-result queue
// popped on each done pulse, latency and control-signal checks.
module tb_ascon_perm_iter;
  import ascon_pack::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  nb_rounds;
  type_state   state_in;
  type_state   state_to_pc;
  logic        input_select;
  type_state   state_out;
  logic        busy;
  logic        done;
  perm_state_t fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [319:0] exp_q[$];
  int           lat_q[$];

  ascon_perm_iter #(.MAX_ROUNDS(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .nb_rounds    (nb_rounds),
    .state_to_pc  (state_to_pc),
    .input_select (input_select),
    .state_out    (state_out),
    .busy         (busy),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  assign state_to_pc = input_select ? state_in : state_out;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic type_state model_round(input type_state s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    r[0] = x0 ^ rot(x0, 19) ^ rot(x0, 28);
    r[1] = x1 ^ rot(x1, 61) ^ rot(x1, 39);
    r[2] = x2 ^ rot(x2, 1)  ^ rot(x2, 6);
    r[3] = x3 ^ rot(x3, 10) ^ rot(x3, 17);
    r[4] = x4 ^ rot(x4, 7)  ^ rot(x4, 41);
    return r;
  endfunction

  function automatic int eff_rounds(input int nb);
    return (nb == 0 || nb > 12) ? 12 : nb;
  endfunction

  function automatic type_state model_perm(input type_state s, input int nb);
    type_state r = s;
    for (int i = 12 - eff_rounds(nb); i < 12; i++) r = model_round(r, i);
    return r;
  endfunction

  // driver tasks: caller is positioned at a negedge
  task automatic drive_start(input type_state s, input logic [3:0] nb);
    state_in  = s;
    nb_rounds = nb;
    start     = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(model_perm(s, int'(nb)));
    lat_q.push_back(cyc + eff_rounds(int'(nb)) - 1);
    start     = 1'b0;
    nb_rounds = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(output int busy_cnt, output int sel_hi);
    busy_cnt = 0;
    sel_hi   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) break;
      busy_cnt += int'(busy);
      sel_hi   += int'(input_select);
    end
    check_eq("done_seen", done, 1);
  endtask

  // scoreboard: compare on every done pulse
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", done, 0);
      end else begin
        check_eq("perm_result", state_out, exp_q.pop_front());
        check_eq("done_latency", cyc, lat_q.pop_front());
      end
    end
  end

  initial begin
    type_state iv_state, s_a, s_b, r0;
    int busy_cnt, sel_hi;

    iv_state[0] = 64'h80400c0600000000;
    iv_state[1] = 64'h0001020304050607;
    iv_state[2] = 64'h08090a0b0c0d0e0f;
    iv_state[3] = 64'h0001020304050607;
    iv_state[4] = 64'h08090a0b0c0d0e0f;
    r0[0] = 64'h001E0F00000000F0;
    r0[1] = 64'h00000001E0000770;
    r0[2] = 64'h3FFFFFFFFFFFFF74;
    r0[3] = 64'h3C780000000000F0;
    r0[4] = 64'h0;

    reset = 1'b1; start = 1'b0; nb_rounds = 4'd0; state_in = '0;
    #1;
    check_eq("rst_state_out", state_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_input_select", input_select, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // single round from zero state, then full p12
    drive_start('0, 4'd12);
    check_eq("round0_zero", state_out, r0);
    check_eq("busy_after_start", busy, 1);
    check_eq("select_in_run", input_select, 0);
    wait_done(busy_cnt, sel_hi);

    drive_start(iv_state, 4'd12);
    wait_done(busy_cnt, sel_hi);
    check_eq("p12_busy_cycles", busy_cnt, 11);
    check_eq("p12_select_high", sel_hi, 0);

    // back-to-back p6 then p8 issued on the done cycle
    for (int w = 0; w < 5; w++) begin
      s_a[w] = {$urandom, $urandom};
      s_b[w] = {$urandom, $urandom};
    end
    drive_start(s_a, 4'd6);
    check_eq("p6_first_rc96", state_out, model_round(s_a, 6));
    wait_done(busy_cnt, sel_hi);
    check_eq("p6_busy_cycles", busy_cnt, 5);
    check_eq("select_on_done", input_select, 1);
    drive_start(s_b, 4'd8);
    check_eq("p8_first_rcB4", state_out, model_round(s_b, 4));
    wait_done(busy_cnt, sel_hi);
    check_eq("p8_busy_cycles", busy_cnt, 7);

    // out-of-range round counts behave as 12
    drive_start(s_a, 4'd0);
    check_eq("nb0_first_rcF0", state_out, model_round(s_a, 0));
    wait_done(busy_cnt, sel_hi);
    drive_start(s_b, 4'd15);
    check_eq("nb15_first_rcF0", state_out, model_round(s_b, 0));
    wait_done(busy_cnt, sel_hi);
    check_eq("nb15_busy_cycles", busy_cnt, 11);

    // single-round permutation
    drive_start(s_a, 4'd1);
    wait_done(busy_cnt, sel_hi);
    check_eq("p1_busy_cycles", busy_cnt, 0);
    @(negedge clock);
    check_eq("hold_in_idle", state_out, model_perm(s_a, 1));

    // start during RUN is ignored
    drive_start(iv_state, 4'd12);
    repeat (4) @(negedge clock);
    state_in = s_b; nb_rounds = 4'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(busy_cnt, sel_hi);
    repeat (15) @(negedge clock);

    // asynchronous reset mid-run
    drive_start(s_b, 4'd12);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_state_out", state_out, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    drive_start(iv_state, 4'd12);
    wait_done(busy_cnt, sel_hi);
    check_eq("post_reset_busy", busy_cnt, 11);

    repeat (10) @(negedge clock);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_perm_iter.md
Name: ascon_perm_iter

Overview:
- Iterative Ascon permutation engine, one round per clock.
- Consumes `state_to_pc` from the input multiplexer.
- Registers the round result as `state_out`, which feeds back to that multiplexer's `state_out` input.
- Drives the multiplexer's `input_select`, counts rounds for p^a/p^b, and flags completion to the Ascon mode FSM.

Parameters:
- `MAX_ROUNDS`, 12, total round-constant schedule length; start index = `MAX_ROUNDS - nb_rounds`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a permutation of `nb_rounds` rounds; sampled only in IDLE.
- `nb_rounds`  in  4  number of rounds (6, 8 or 12 nominal).
- `state_to_pc`  in  `type_state` (5x64)  multiplexer output; round input.
- `input_select`  out  1  multiplexer select: 1 = external `state_in`, 0 = `state_out` feedback.
- `state_out`  out  `type_state`  registered state after the last executed round.
- `busy`  out  1  high while rounds remain after the current edge.
- `done`  out  1  one-cycle pulse; `state_out` holds the final result.

Behaviour:
- Reset (async, high):
  - `state_out` = all zero, round counter = 0, FSM = IDLE.
  - `busy` = 0, `done` = 0.
  - Recovery is on the first rising edge after deassertion.
- States: IDLE, RUN.
- `input_select` is combinational: 1 in IDLE, 0 in RUN.
- Round function R(x, i), applied to `state_to_pc` with counter i:
  - Constant addition: x2 ^= {56'b0, ((4'hF - i) << 4) | i}.
  - 5-bit S-box: x0 is the MSB of each column.
  - Linear layer, rotate right:
    - x0: 19, 28
    - x1: 61, 39
    - x2: 1, 6
    - x3: 10, 17
    - x4: 7, 41
- Effective rounds N:
  - `nb_rounds` in 1..12 → N = `nb_rounds`.
  - `nb_rounds` = 0 or > 12 → N = 12.
  - Start index s = 12 − N.
- IDLE, `start` = 1 at an edge:
  - `state_out` <= R(`state_to_pc`, s), counter <= s+1.
  - If N > 1 → RUN, `busy` <= 1.
  - If N = 1 → stay IDLE, `done` <= 1.
- RUN, each edge:
  - `state_out` <= R(`state_to_pc`, counter), where `state_to_pc` = `state_out` via the mux.
  - counter <= counter+1.
  - When counter = 11 at this edge → IDLE, `busy` <= 0, `done` <= 1.
- Latency: start sampled at edge E0 → final state registered at edge E0+N−1 → `done` high during the following cycle.
  - Example: N = 12 gives `done` 12 cycles after the start edge, counting the start edge's cycle as 1.
- `done` is high for exactly one cycle.
- `state_out` holds its value in IDLE until the next start.
- `start` while RUN is ignored, with no queueing.
- `start` in the same cycle that `done` is high is accepted; back-to-back permutations are allowed.
- `nb_rounds` is sampled only on the accepted start edge; changes during RUN have no effect.
- Counter is 4 bits and never exceeds 11 while RUN.
- Reset during RUN aborts immediately: `state_out` is cleared and no `done` is produced.

Decomposition:
- `ascon_pack` holds:
  - `type_state` (array of 5 x 64-bit words)
  - the S-box lookup constant (32 x 5-bit)
  - `round_constant(i)` function
  - rotation amount constants
- Sub-module `ascon_round`: purely combinational R(x, i), with ports state_i, round_i[3:0], state_o.
- `ascon_perm_iter` itself holds the FSM, counter and state register.

Test Plan:
- `ascon_round` unit test: zero state, i = 0 → x0=64'h001E0F00000000F0, x1=64'h00000001E0000770, x2=64'h3FFFFFFFFFFFFF74, x3=64'h3C780000000000F0, x4=0.
- `start`, `nb_rounds`=12, `state_in` = Ascon-128 IV‖K‖N golden vector:
  - `input_select`=1 only on the start cycle.
  - `done` pulses exactly once, 12 cycles later.
  - `state_out` matches the C reference p12.
  - `busy` is high for 11 cycles.
- `nb_rounds`=6 then `nb_rounds`=8, issued back-to-back on the `done` cycle: round constants used are 0x96..0x4B and 0xB4..0x4B; results match the reference p6/p8.
- `nb_rounds`=0 and `nb_rounds`=15 → behave as 12: 12-cycle latency, constants start at 0xF0.
- `start` pulsed during RUN at round 5 → ignored: single `done`, result unchanged versus the clean run.
- Reset asserted mid-RUN (asynchronously, between edges):
  - `state_out`=0, `busy`=0, `done`=0 immediately.
  - After release, a new start with N=12 produces the correct p12.
